bnn_dense_seq: RTL and testbench

- Sequential, parametrised binary fully-connected (XNOR-popcount) layer for the BNN inference datapath.
- Evaluates one neuron per clock against a runtime-loadable weight/threshold store.
- Valid/ready handshakes on input and output let layers chain directly. Two instances (75->50, 50->10) form the current two-layer network.

---
 rtl/bnn_dense_seq.sv | 125 ++++++++++++
 tb/tb_bnn_dense_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_dense_seq.sv
// Sequential binary dense layer: one XNOR-popcount neuron per clock against a
// runtime-loadable weight/threshold store, with valid/ready on both sides.
module bnn_dense_seq #(
    parameter int N_IN  = 75,
    parameter int N_OUT = 50,
    parameter int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter int TW    = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [N_IN-1:0]  cfg_weight,
    input  logic [TW-1:0]    cfg_thresh,
    output logic             cfg_ready,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic [N_IN-1:0]  r_x;
    logic [N_IN-1:0]  r_w [N_OUT];
    logic [TW-1:0]    r_t [N_OUT];
    logic [N_OUT-1:0] r_shadow;
    logic [N_OUT-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_busy;

    logic [N_IN-1:0]  w_xnor;
    logic [TW-1:0]    w_pop;
    logic             w_bit;
    logic [N_OUT-1:0] w_shadow_nxt;
    logic             w_cfg_ok;
    logic             w_last;

    assign w_xnor   = ~(r_x ^ r_w[r_cnt]);
    assign w_bit    = (w_pop >= r_t[r_cnt]);
    assign w_last   = (r_cnt == AW'(N_OUT - 1));
    assign w_cfg_ok = cfg_we && (r_state == S_IDLE) &&
                      ({1'b0, cfg_addr} < (AW + 1)'(N_OUT));

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_pop = w_pop + TW'(w_xnor[i]);
        end
    end

    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_cnt] = w_bit;
    end

    // NOTE: the store is a register file, not a RAM, because reset must clear every row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_w[j] <= '0;
                r_t[j] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_w[cfg_addr] <= cfg_weight;
            r_t[cfg_addr] <= cfg_thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_shadow <= w_shadow_nxt;
                    if (w_last) begin
                        // The final neuron's bit goes straight into out_data with the rest.
                        r_cnt       <= '0;
                        r_out_data  <= w_shadow_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign cfg_ready = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bnn_dense_seq.sv
// Scoreboard bench for bnn_dense_seq: a monitor pushes model results on input
// handshakes and compares them on output handshakes.
module tb_bnn_dense_seq;

    localparam int N_IN  = 75;
    localparam int N_OUT = 50;
    localparam int AW    = 6;
    localparam int TW    = 7;

    typedef logic [N_OUT-1:0] res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_data;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [N_IN-1:0]  cfg_weight;
    logic [TW-1:0]    cfg_thresh;
    logic             cfg_ready;
    logic             busy;

    bnn_dense_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
        .cfg_thresh(cfg_thresh), .cfg_ready(cfg_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [N_IN-1:0] m_w [N_OUT];
    logic [TW-1:0]   m_t [N_OUT];
    res_t            exp_q[$];
    int              acc_edge = 0;
    int              prev_acc = 0;
    bit              have_prev = 0;
    bit              chk_ii = 0;
    bit              prev_ov = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [N_IN-1:0] x);
        res_t r;
        for (int j = 0; j < N_OUT; j++) begin
            r[j] = ($countones(~(x ^ m_w[j])) >= int'(m_t[j]));
        end
        return r;
    endfunction

    function automatic logic [N_IN-1:0] ones_low(input int n);
        logic [N_IN-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N_IN-1:0] rand_vec();
        return N_IN'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Monitor: model updates on accepted config, push on input handshake, compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                m_w[j] = '0;
                m_t[j] = '0;
            end
            exp_q.delete();
            prev_ov   = 1'b0;
            have_prev = 1'b0;
        end else begin
            if (!chk_ii) have_prev = 1'b0;
            if (cfg_we && cfg_ready && int'(cfg_addr) < N_OUT) begin
                m_w[cfg_addr] = cfg_weight;
                m_t[cfg_addr] = cfg_thresh;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                acc_edge = cyc + 1;
                if (chk_ii && have_prev) check("init_interval", acc_edge - prev_acc, N_OUT + 2);
                prev_acc  = acc_edge;
                have_prev = 1'b1;
            end
            if (out_valid && !prev_ov) check("latency", cyc - acc_edge, N_OUT);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_empty", 0, 1);
                else check("out_data", out_data, exp_q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    task automatic cfg_write(input int addr, input logic [N_IN-1:0] w, input int t);
        cfg_we     = 1'b1;
        cfg_addr   = AW'(addr);
        cfg_weight = w;
        cfg_thresh = TW'(t);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [N_IN-1:0] x);
        in_data  = x;
        in_valid = 1'b1;
        for (int n = 0; !in_ready && n < 200; n++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) check("in_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        for (int n = 0; !out_valid && n < budget; n++) begin
            @(posedge clk); #1;
        end
        if (!out_valid) check("out_timeout", out_valid, 1);
    endtask

    task automatic recv();
        wait_out(200);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN-1:0] x3;
        logic [N_IN-1:0] x4;
        logic [N_IN-1:0] vecs [3];
        res_t            held;

        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_weight = '0; cfg_thresh = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);

        // Default store: threshold 0 makes every neuron fire.
        send({N_IN{1'b1}});
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
        recv();
        check("t1_all_ones", out_data, {N_OUT{1'b1}});
        check("t1_idle_busy", busy, 0);

        for (int j = 0; j < N_OUT; j++) cfg_write(j, {N_IN{1'b1}}, 38);
        send(ones_low(38));
        recv();
        check("t2_38_ones", out_data, {N_OUT{1'b1}});
        send(ones_low(37));
        recv();
        check("t2_37_ones", out_data, 0);

        // Mixed neurons; the row-49 write shares the edge with the input handshake.
        x3 = rand_vec();
        cfg_write(0, ~x3, 1);
        cfg_write(5, x3, 76);
        in_data = x3; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_addr = AW'(49); cfg_weight = x3; cfg_thresh = TW'(75);
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        check("t3_accepted", busy, 1);
        recv();
        check("t3_bit0", out_data[0], 0);
        check("t3_bit5", out_data[5], 0);
        check("t3_bit49", out_data[49], 1);

        // Backpressure: result held, input and config ignored while in DONE.
        x4 = ones_low(60);
        send(x4);
        wait_out(200);
        held = exp_q[0];
        check("t4_bit1_model", held[1], 1);
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", out_data, held);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            if (i == 5) begin
                in_valid = 1'b1; in_data = rand_vec();
                cfg_we = 1'b1; cfg_addr = AW'(1); cfg_weight = ~x4; cfg_thresh = TW'(1);
            end else begin
                in_valid = 1'b0; cfg_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cfg_we = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_back_idle", busy, 0);
        send(x4);
        recv();
        check("bp_weights_kept", out_data, held);

        // Back-to-back with in_valid and out_ready held high.
        vecs[0] = rand_vec(); vecs[1] = rand_vec(); vecs[2] = {N_IN{1'b1}};
        chk_ii = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(vecs[k]);
        wait_out(200);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_ii = 1'b0;
        check("b2b_last_nonzero", out_data[1], 1);

        // Asynchronous reset in the middle of a run.
        send({N_IN{1'b1}});
        repeat (10) @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_data", out_data, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_write(50, '0, 100);
        send(rand_vec());
        recv();
        check("post_rst_default", out_data, {N_OUT{1'b1}});

        @(posedge clk); #1;
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
